// File: rtl/light_rx_buffer.sv
// light_rx_buffer: receive FIFO behind the LightIO decoder.
// Captures one byte per rising edge of rx_irq into a circular buffer
// and hands words to the host through a registered pop handshake.
`ifndef PACKET_SIZE
`define PACKET_SIZE 8
`endif

module light_rx_buffer #(
  parameter int PACKET_SIZE = `PACKET_SIZE,
  parameter int ADDR_W      = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [PACKET_SIZE-1:0] rx_data,
  input  logic                   rx_irq,
  input  logic                   rd_req,
  output logic [PACKET_SIZE-1:0] rd_data,
  output logic                   rd_valid,
  output logic [ADDR_W:0]        count,
  output logic                   empty,
  output logic                   full,
  output logic                   host_irq,
  output logic                   overflow,
  input  logic                   ovf_clear
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  logic [PACKET_SIZE-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]        count_q, count_d;
  logic [PACKET_SIZE-1:0] rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   overflow_q, overflow_d;
  logic                   irq_q, irq_d;
  logic                   capture, is_empty, is_full, pop, push, drop;

  // Next-state: edge detect, push/pop arbitration on pre-edge occupancy.
  always_comb begin
    irq_d      = rx_irq;
    capture    = rx_irq & ~irq_q;
    is_empty   = (count_q == '0);
    is_full    = (count_q == DEPTH_C);
    pop        = rd_req & ~is_empty;
    // A full buffer still accepts a byte when a pop frees a slot this cycle.
    push       = capture & (~is_full | pop);
    drop       = capture & is_full & ~pop;
    wr_ptr_d   = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    rd_data_d  = pop  ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid_d = pop;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    // Set wins over clear when both land in the same cycle.
    overflow_d = drop ? 1'b1 : (ovf_clear ? 1'b0 : overflow_q);
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  // Storage array; contents are left untouched by reset.
  always_ff @(posedge clock) begin
    if (reset && push) mem_q[wr_ptr_q] <= rx_data;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign host_irq = (count_q != '0);
  assign overflow = overflow_q;
endmodule

// File: doc/light_rx_buffer.md
# light_rx_buffer

Receive-side packet buffer sitting directly downstream of the `decoder` in the LightIO link. It captures each byte the decoder reports via `irq`, stores it in a circular FIFO, and presents it to the host through a pop handshake. Occupancy, full/empty, a host interrupt and a sticky overflow flag are also provided. Words are `PACKET_SIZE` bits wide, matching `definitions.v`.

## Interface
- `PACKET_SIZE`, default `` `PACKET_SIZE `` (8): word width; equals the decoder `data` width.
- `ADDR_W`, default 3: pointer width; depth `DEPTH = 2**ADDR_W` (8); `ADDR_W >= 1`.

- `clock` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low; sampled on the `clock` rising edge.
- `rx_data` in PACKET_SIZE: decoder `data` output.
- `rx_irq` in 1: decoder `irq`; may be a pulse or a multi-cycle level.
- `rd_req` in 1: host pop request, sampled every cycle.
- `rd_data` out PACKET_SIZE: popped word, registered.
- `rd_valid` out 1: one-cycle strobe qualifying `rd_data`.
- `count` out ADDR_W+1: occupancy, 0..DEPTH.
- `empty` out 1: `count == 0`.
- `full` out 1: `count == DEPTH`.
- `host_irq` out 1: level, equals `!empty`.
- `overflow` out 1: sticky; a byte was dropped.
- `ovf_clear` in 1: clears `overflow`.

## Operation
- Reset (`reset == 0` at an edge): `wr_ptr = rd_ptr = 0`, `count = 0`, `empty = 1`, `full = 0`, `host_irq = 0`, `overflow = 0`, `rd_valid = 0`, `rd_data = 0`, `irq_q = 1`. FIFO memory contents are not reset. Reset overrides all other inputs in that cycle.
- Edge detect:
  - `irq_q` registers `rx_irq` every cycle.
  - `capture = rx_irq & ~irq_q`: exactly one capture per `irq` assertion, however long it is held.
  - Because `irq_q` resets to 1, an `rx_irq` already high when reset is released is not captured.
- Push: on `capture`, `rx_data` is sampled in that same cycle.
  - Not full: write `mem[wr_ptr]`, then `wr_ptr++`.
  - Full and no accepted pop: byte dropped, `overflow <= 1`; pointers and `count` unchanged.
- Pop: if `rd_req & !empty`:
  - `rd_data <= mem[rd_ptr]`, `rd_ptr++`, `rd_valid <= 1`.
  - Otherwise `rd_valid <= 0` and `rd_data` holds its last value.
  - `rd_req` while empty is ignored: no error, no pointer change.
- Simultaneous events. Full and empty are evaluated on the pre-edge `count`.
  - Push and pop, neither full nor empty: both performed, `count` unchanged.
  - Full with capture and accepted pop: both performed, no overflow, `count` stays DEPTH.
  - Empty with capture and `rd_req`: push only; pop ignored, `count` goes to 1.
  - `ovf_clear` and a drop in the same cycle: set wins, `overflow = 1`.
- Pointers are ADDR_W bits and wrap modulo DEPTH. Full/empty are derived from `count`, not from pointer comparison.
- `count`, `empty`, `full` and `host_irq` are registered or derived from registered `count`, with no combinational path from inputs.

## Timing
- Capture latency: `rx_irq` first sampled high at edge k.
  - Entry written at edge k.
  - `count`, `empty` and `host_irq` reflect it from edge k onward (one cycle after `rx_irq` rises).
- Read latency: `rd_req` sampled high at edge n with `!empty`.
  - `rd_data`/`rd_valid` are valid in the cycle after edge n.
  - `count` decrements at edge n.
- Throughput: one push and one pop per cycle. Back-to-back `rd_req` drains one word per cycle, with `rd_valid` held high for consecutive cycles.
- Read-after-write: a word pushed at edge k can be popped by `rd_req` sampled at edge k+1 at the earliest.
- `overflow` rises one cycle after the dropping capture. It clears one cycle after `ovf_clear` is sampled high, provided no drop occurs in the same cycle.

## Test plan
- Reset and single byte:
  - Stimulus: hold `reset = 0` with `rx_irq = 1`, release, then drop `rx_irq`, then pulse `rx_irq` with `rx_data = 8'b1011_0110`.
  - Required: no capture at reset release; `count = 1`, `host_irq = 1`.
  - Then assert `rd_req` for 1 cycle: next cycle `rd_data = 8'hB6`, `rd_valid = 1`; then `empty = 1`.
- Long `irq` level:
  - Stimulus: hold `rx_irq` high for 5 cycles with `rx_data = 8'b1111_0100`.
  - Required: exactly one entry, `count = 1`.
- Fill and overflow:
  - Stimulus: 9 captures of 0x01..0x09 with no reads.
  - Required: `full = 1` after the 8th, `overflow = 1` after the 9th, `count = 8`.
  - Then drain: 0x01..0x08 in order; 0x09 absent.
  - Then pulse `ovf_clear`: `overflow = 0`.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full with 0x10..0x17; capture 0x18 in the same cycle as `rd_req`.
  - Required: pops 0x10, `count` stays 8, no overflow; a subsequent full drain returns 0x11..0x18, exercising pointer wrap.
- Empty with simultaneous push and pop:
  - Stimulus: FIFO empty; capture 0x5A in the same cycle as `rd_req`.
  - Required: `rd_valid` stays 0, `count = 1`; the next `rd_req` yields 0x5A.
- Reset mid-operation:
  - Stimulus: with 3 entries stored, assert `reset = 0` for 1 cycle.
  - Required: `count = 0`, `empty = 1`, `rd_valid = 0`, `overflow = 0`.
  - Then `rd_req`: no `rd_valid`.
